// File: rtl/instr_fetch_register_pkg.sv
// ---------------------------------------------------------------------------
// instr_fetch_register_pkg
// Shared definitions for the instruction fetch register:
//   - fetch FSM state encoding
//   - bit positions of the instruction fields
//   - default program counter reset value
// ---------------------------------------------------------------------------
package instr_fetch_register_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_t;

    localparam int INSTR_W   = 16;

    // Instruction layout: [15:12] opcode, [11:8] Rdest,
    // [7:4] upper immediate / OpExt, [3:0] lower immediate / Rsrc.
    localparam int OPC_HI    = 15;
    localparam int OPC_LO    = 12;
    localparam int RDEST_HI  = 11;
    localparam int RDEST_LO  = 8;
    localparam int IMM_UP_HI = 7;
    localparam int IMM_UP_LO = 4;
    localparam int IMM_LO_HI = 3;
    localparam int IMM_LO_LO = 0;

    localparam logic [15:0] PC_RESET_DEFAULT = 16'h0000;

endpackage

// File: rtl/instr_fetch_register_pc_register.sv
// ---------------------------------------------------------------------------
// instr_fetch_register_pc_register
// Program counter register for the fetch unit.
//   clk       : rising-edge clock
//   reset     : asynchronous active-low reset, loads PC_RESET
//   load_en   : load load_addr (branch/jump); wins over inc_en
//   load_addr : new program counter value
//   inc_en    : advance by one, wrapping from all-ones to zero
//   pc        : current program counter
// ---------------------------------------------------------------------------
module instr_fetch_register_pc_register #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              inc_en,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_q;

    always_comb begin
        pc_d = pc_q;
        if (load_en) begin
            pc_d = load_addr;
        end else if (inc_en) begin
            // Natural modulo-2^ADDR_W wrap.
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= PC_RESET;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_register.sv
// ---------------------------------------------------------------------------
// instr_fetch_register
// Fetches 16-bit instructions from instruction memory at the program counter,
// holds each one in a register and presents its fields to decode. The two
// immediate nibbles feed the immediate sign-extender.
//
// Ports:
//   clk, reset      : rising-edge clock, asynchronous active-low reset
//   enable          : allow new fetches to start
//   mem_rd_en       : one-cycle read strobe to instruction memory
//   mem_addr        : read address, meaningful while mem_rd_en=1
//   mem_rdata       : instruction word, valid MEM_LAT cycles after the strobe
//   instr_ready     : consumer accepts the held instruction this cycle
//   redirect        : branch/jump taken, restart fetch at redirect_addr
//   redirect_addr   : new program counter
//   instr_valid     : held instruction and fields are valid
//   instr           : held instruction word
//   opcode/rdest    : instr[15:12] / instr[11:8]
//   imm_upper       : instr[7:4] (OpExt), sign-extender upper input
//   imm_lower       : instr[3:0] (Rsrc), sign-extender lower input
//   pc_out          : address the held instruction was fetched from
// ---------------------------------------------------------------------------
module instr_fetch_register
    import instr_fetch_register_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                MEM_LAT  = 1,
    parameter logic [ADDR_W-1:0] PC_RESET = ADDR_W'(PC_RESET_DEFAULT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_addr,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [3:0]         opcode,
    output logic [3:0]         rdest,
    output logic [3:0]         imm_upper,
    output logic [3:0]         imm_lower,
    output logic [ADDR_W-1:0]  pc_out
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);

    fetch_state_t       state_d,       state_q;
    logic [CNT_W-1:0]   cnt_d,         cnt_q;
    logic               mem_rd_en_d,   mem_rd_en_q;
    logic [ADDR_W-1:0]  mem_addr_d,    mem_addr_q;
    logic [INSTR_W-1:0] instr_d,       instr_q;
    logic               instr_valid_d, instr_valid_q;
    logic [ADDR_W-1:0]  pc_out_d,      pc_out_q;

    logic [ADDR_W-1:0]  pc;
    logic               capture;

    instr_fetch_register_pc_register #(
        .ADDR_W   (ADDR_W),
        .PC_RESET (PC_RESET)
    ) u_pc_register (
        .clk       (clk),
        .reset     (reset),
        .load_en   (redirect),
        .load_addr (redirect_addr),
        .inc_en    (capture),
        .pc        (pc)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mem_rd_en_d   = 1'b0;
        mem_addr_d    = '0;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        pc_out_d      = pc_out_q;
        capture       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d     = ST_REQ;
                    mem_rd_en_d = 1'b1;
                    mem_addr_d  = pc;
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
                cnt_d   = CNT_W'(MEM_LAT);
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                // Counter hits zero on this edge: memory data is valid now.
                if (cnt_q == CNT_W'(1)) begin
                    capture       = 1'b1;
                    instr_d       = mem_rdata;
                    pc_out_d      = pc;
                    instr_valid_d = 1'b1;
                    state_d       = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (instr_ready) begin
                    instr_valid_d = 1'b0;
                    if (enable) begin
                        state_d     = ST_REQ;
                        mem_rd_en_d = 1'b1;
                        mem_addr_d  = pc;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Redirect overrides everything: drop any in-flight read (including
        // one completing on this edge) and restart at the new address.
        if (redirect) begin
            capture       = 1'b0;
            instr_d       = instr_q;
            pc_out_d      = pc_out_q;
            instr_valid_d = 1'b0;
            cnt_d         = '0;
            if (enable) begin
                state_d     = ST_REQ;
                mem_rd_en_d = 1'b1;
                mem_addr_d  = redirect_addr;
            end else begin
                state_d     = ST_IDLE;
                mem_rd_en_d = 1'b0;
                mem_addr_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            mem_rd_en_q   <= 1'b0;
            mem_addr_q    <= '0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            pc_out_q      <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mem_rd_en_q   <= mem_rd_en_d;
            mem_addr_q    <= mem_addr_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            pc_out_q      <= pc_out_d;
        end
    end

    assign mem_rd_en   = mem_rd_en_q;
    assign mem_addr    = mem_addr_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[OPC_HI:OPC_LO];
    assign rdest       = instr_q[RDEST_HI:RDEST_LO];
    assign imm_upper   = instr_q[IMM_UP_HI:IMM_UP_LO];
    assign imm_lower   = instr_q[IMM_LO_HI:IMM_LO_LO];
    assign pc_out      = pc_out_q;

endmodule

// File: tb/tb_instr_fetch_register.sv
// Two fetch units share the clock: index 0 has MEM_LAT=1, PC_RESET=0;
// index 1 has MEM_LAT=3, PC_RESET=16'h0100. Each has its own memory model.
module tb_instr_fetch_register;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset         [2];
    logic        enable        [2];
    logic        instr_ready   [2];
    logic        redirect      [2];
    logic [15:0] redirect_addr [2];
    logic        mem_rd_en     [2];
    logic [15:0] mem_addr      [2];
    logic [15:0] mem_rdata     [2];
    logic        instr_valid   [2];
    logic [15:0] instr         [2];
    logic [3:0]  opcode        [2];
    logic [3:0]  rdest         [2];
    logic [3:0]  imm_upper     [2];
    logic [3:0]  imm_lower     [2];
    logic [15:0] pc_out        [2];

    int pass_cnt  = 0;
    int total_cnt = 0;

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic [15:0] pcr_of(input int d);
        return (d == 0) ? 16'h0000 : 16'h0100;
    endfunction

    // Instruction memory contents.
    function automatic logic [15:0] memval(input logic [15:0] a);
        if (a == 16'h0000) return 16'h5A3F;
        if (a == 16'h0001) return 16'hB1F0;
        return (a * 16'h9E37) ^ 16'h1234;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [15:0] ahist [1:3];
        logic        vhist [1:3];

        // Memory: returns the word for a strobe exactly LAT cycles later,
        // junk at all other times.
        always @(posedge clk) begin
            ahist[1] <= mem_addr[g];
            vhist[1] <= mem_rd_en[g];
            for (int k = 2; k <= 3; k++) begin
                ahist[k] <= ahist[k-1];
                vhist[k] <= vhist[k-1];
            end
        end
        assign mem_rdata[g] = vhist[LAT] ? memval(ahist[LAT]) : 16'hDEAD;

        instr_fetch_register #(
            .ADDR_W   (16),
            .MEM_LAT  (LAT),
            .PC_RESET ((g == 0) ? 16'h0000 : 16'h0100)
        ) u_dut (
            .clk           (clk),
            .reset         (reset[g]),
            .enable        (enable[g]),
            .mem_rd_en     (mem_rd_en[g]),
            .mem_addr      (mem_addr[g]),
            .mem_rdata     (mem_rdata[g]),
            .instr_ready   (instr_ready[g]),
            .redirect      (redirect[g]),
            .redirect_addr (redirect_addr[g]),
            .instr_valid   (instr_valid[g]),
            .instr         (instr[g]),
            .opcode        (opcode[g]),
            .rdest         (rdest[g]),
            .imm_upper     (imm_upper[g]),
            .imm_lower     (imm_lower[g]),
            .pc_out        (pc_out[g])
        );
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs(input int d);
        enable[d]        = 1'b0;
        instr_ready[d]   = 1'b0;
        redirect[d]      = 1'b0;
        redirect_addr[d] = 16'h0000;
    endtask

    task automatic wait_strobe(input int d, input int max, output bit seen, output int cyc);
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < max) begin
            step();
            cyc++;
            if (mem_rd_en[d] === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic wait_valid(input int d, input int max, output bit seen, output int cyc);
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < max) begin
            step();
            cyc++;
            if (instr_valid[d] === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset(input int d);
        idle_inputs(d);
        reset[d] = 1'b0;
        step();
        step();
        total_cnt++; if (instr_valid[d] !== 1'b0) $display("FAIL d%0d reset_valid: got %h expected 0", d, instr_valid[d]); else pass_cnt++;
        total_cnt++; if (mem_rd_en[d] !== 1'b0) $display("FAIL d%0d reset_rd_en: got %h expected 0", d, mem_rd_en[d]); else pass_cnt++;
        total_cnt++; if (mem_addr[d] !== 16'h0) $display("FAIL d%0d reset_addr: got %h expected 0", d, mem_addr[d]); else pass_cnt++;
        total_cnt++; if (instr[d] !== 16'h0) $display("FAIL d%0d reset_instr: got %h expected 0", d, instr[d]); else pass_cnt++;
        total_cnt++; if ({opcode[d], rdest[d], imm_upper[d], imm_lower[d]} !== 16'h0) $display("FAIL d%0d reset_fields: got %h expected 0", d, {opcode[d], rdest[d], imm_upper[d], imm_lower[d]}); else pass_cnt++;
        total_cnt++; if (pc_out[d] !== 16'h0) $display("FAIL d%0d reset_pc_out: got %h expected 0", d, pc_out[d]); else pass_cnt++;
        reset[d] = 1'b1;
        step();
    endtask

    task automatic test_basic_fetch();
        enable[0] = 1'b1;
        instr_ready[0] = 1'b0;
        step();
        total_cnt++; if (mem_rd_en[0] !== 1'b1) $display("FAIL basic_strobe: got %h expected 1", mem_rd_en[0]); else pass_cnt++;
        total_cnt++; if (mem_addr[0] !== 16'h0000) $display("FAIL basic_addr: got %h expected 0000", mem_addr[0]); else pass_cnt++;
        step();
        total_cnt++; if (mem_rd_en[0] !== 1'b0) $display("FAIL basic_strobe_len: got %h expected 0", mem_rd_en[0]); else pass_cnt++;
        total_cnt++; if (instr_valid[0] !== 1'b0) $display("FAIL basic_early_valid: got %h expected 0", instr_valid[0]); else pass_cnt++;
        step();
        total_cnt++; if (instr_valid[0] !== 1'b1) $display("FAIL basic_valid: got %h expected 1", instr_valid[0]); else pass_cnt++;
        total_cnt++; if (instr[0] !== 16'h5A3F) $display("FAIL basic_instr: got %h expected 5a3f", instr[0]); else pass_cnt++;
        total_cnt++; if (opcode[0] !== 4'h5) $display("FAIL basic_opcode: got %h expected 5", opcode[0]); else pass_cnt++;
        total_cnt++; if (rdest[0] !== 4'hA) $display("FAIL basic_rdest: got %h expected a", rdest[0]); else pass_cnt++;
        total_cnt++; if (imm_upper[0] !== 4'h3) $display("FAIL basic_imm_upper: got %h expected 3", imm_upper[0]); else pass_cnt++;
        total_cnt++; if (imm_lower[0] !== 4'hF) $display("FAIL basic_imm_lower: got %h expected f", imm_lower[0]); else pass_cnt++;
        total_cnt++; if (pc_out[0] !== 16'h0000) $display("FAIL basic_pc_out: got %h expected 0000", pc_out[0]); else pass_cnt++;
    endtask

    task automatic test_stall();
        bit seen;
        int cyc;
        instr_ready[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            total_cnt++; if ({instr_valid[0], mem_rd_en[0], instr[0]} !== {1'b1, 1'b0, 16'h5A3F}) $display("FAIL stall_hold cycle %0d: got valid=%h rd_en=%h instr=%h expected 1 0 5a3f", i, instr_valid[0], mem_rd_en[0], instr[0]); else pass_cnt++;
        end
        instr_ready[0] = 1'b1;
        step();
        instr_ready[0] = 1'b0;
        total_cnt++; if ({mem_rd_en[0], instr_valid[0]} !== 2'b10) $display("FAIL stall_release: got rd_en=%h valid=%h expected 1 0", mem_rd_en[0], instr_valid[0]); else pass_cnt++;
        total_cnt++; if (mem_addr[0] !== 16'h0001) $display("FAIL stall_next_addr: got %h expected 0001", mem_addr[0]); else pass_cnt++;
        wait_valid(0, 10, seen, cyc);
        total_cnt++; if (seen !== 1'b1) $display("FAIL stall_second_timeout: got %0d cycles expected valid", cyc); else pass_cnt++;
        total_cnt++; if (instr[0] !== 16'hB1F0) $display("FAIL stall_second_instr: got %h expected b1f0", instr[0]); else pass_cnt++;
        total_cnt++; if ({opcode[0], imm_upper[0], imm_lower[0]} !== 12'hBF0) $display("FAIL stall_second_fields: got %h expected bf0", {opcode[0], imm_upper[0], imm_lower[0]}); else pass_cnt++;
        total_cnt++; if (pc_out[0] !== 16'h0001) $display("FAIL stall_second_pc_out: got %h expected 0001", pc_out[0]); else pass_cnt++;
    endtask

    task automatic test_enable_gate();
        bit seen;
        int cyc;
        enable[0] = 1'b0;
        instr_ready[0] = 1'b1;
        step();
        instr_ready[0] = 1'b0;
        total_cnt++; if (instr_valid[0] !== 1'b0) $display("FAIL gate_valid_drop: got %h expected 0", instr_valid[0]); else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            step();
            total_cnt++; if (mem_rd_en[0] !== 1'b0) $display("FAIL gate_no_strobe cycle %0d: got %h expected 0", i, mem_rd_en[0]); else pass_cnt++;
        end
        enable[0] = 1'b1;
        wait_strobe(0, 5, seen, cyc);
        total_cnt++; if (seen !== 1'b1) $display("FAIL gate_restart_timeout: got %0d cycles expected strobe", cyc); else pass_cnt++;
        total_cnt++; if (mem_addr[0] !== 16'h0002) $display("FAIL gate_restart_addr: got %h expected 0002", mem_addr[0]); else pass_cnt++;
        enable[0] = 1'b0;
        instr_ready[0] = 1'b1;
        repeat (5) step();
        instr_ready[0] = 1'b0;
    endtask

    task automatic test_wrap();
        bit seen;
        int cyc;
        enable[0] = 1'b1;
        instr_ready[0] = 1'b0;
        redirect[0] = 1'b1;
        redirect_addr[0] = 16'hFFFF;
        step();
        redirect[0] = 1'b0;
        total_cnt++; if ({mem_rd_en[0], mem_addr[0]} !== {1'b1, 16'hFFFF}) $display("FAIL wrap_first_strobe: got rd_en=%h addr=%h expected 1 ffff", mem_rd_en[0], mem_addr[0]); else pass_cnt++;
        wait_valid(0, 10, seen, cyc);
        total_cnt++; if (seen !== 1'b1) $display("FAIL wrap_valid_timeout: got %0d cycles expected valid", cyc); else pass_cnt++;
        total_cnt++; if (pc_out[0] !== 16'hFFFF) $display("FAIL wrap_pc_out: got %h expected ffff", pc_out[0]); else pass_cnt++;
        total_cnt++; if (instr[0] !== memval(16'hFFFF)) $display("FAIL wrap_instr: got %h expected %h", instr[0], memval(16'hFFFF)); else pass_cnt++;
        instr_ready[0] = 1'b1;
        step();
        instr_ready[0] = 1'b0;
        total_cnt++; if ({mem_rd_en[0], mem_addr[0]} !== {1'b1, 16'h0000}) $display("FAIL wrap_next_strobe: got rd_en=%h addr=%h expected 1 0000", mem_rd_en[0], mem_addr[0]); else pass_cnt++;
        wait_valid(0, 10, seen, cyc);
        total_cnt++; if ({pc_out[0], instr[0]} !== {16'h0000, 16'h5A3F}) $display("FAIL wrap_after: got pc_out=%h instr=%h expected 0000 5a3f", pc_out[0], instr[0]); else pass_cnt++;
        enable[0] = 1'b0;
        instr_ready[0] = 1'b1;
        repeat (3) step();
        instr_ready[0] = 1'b0;
    endtask

    task automatic test_redirect_wait();
        bit seen;
        int cyc;
        enable[1] = 1'b1;
        instr_ready[1] = 1'b0;
        redirect[1] = 1'b1;
        redirect_addr[1] = 16'h0004;
        step();
        redirect[1] = 1'b0;
        total_cnt++; if ({mem_rd_en[1], mem_addr[1]} !== {1'b1, 16'h0004}) $display("FAIL redir_first_strobe: got rd_en=%h addr=%h expected 1 0004", mem_rd_en[1], mem_addr[1]); else pass_cnt++;
        step();
        redirect[1] = 1'b1;
        redirect_addr[1] = 16'h0040;
        step();
        redirect[1] = 1'b0;
        total_cnt++; if ({mem_rd_en[1], mem_addr[1], instr_valid[1]} !== {1'b1, 16'h0040, 1'b0}) $display("FAIL redir_new_strobe: got rd_en=%h addr=%h valid=%h expected 1 0040 0", mem_rd_en[1], mem_addr[1], instr_valid[1]); else pass_cnt++;
        wait_valid(1, 10, seen, cyc);
        total_cnt++; if (cyc !== 4) $display("FAIL redir_latency: got %0d cycles expected 4", cyc); else pass_cnt++;
        total_cnt++; if (pc_out[1] !== 16'h0040) $display("FAIL redir_pc_out: got %h expected 0040", pc_out[1]); else pass_cnt++;
        total_cnt++; if (instr[1] !== memval(16'h0040)) $display("FAIL redir_instr: got %h expected %h", instr[1], memval(16'h0040)); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        bit seen;
        int cyc;
        enable[1] = 1'b1;
        instr_ready[1] = 1'b1;
        step();
        instr_ready[1] = 1'b0;
        total_cnt++; if ({mem_rd_en[1], mem_addr[1]} !== {1'b1, 16'h0041}) $display("FAIL areset_pre_strobe: got rd_en=%h addr=%h expected 1 0041", mem_rd_en[1], mem_addr[1]); else pass_cnt++;
        step();
        #2;
        reset[1] = 1'b0;
        #1;
        total_cnt++; if ({instr_valid[1], mem_rd_en[1]} !== 2'b00) $display("FAIL areset_ctrl: got valid=%h rd_en=%h expected 0 0", instr_valid[1], mem_rd_en[1]); else pass_cnt++;
        total_cnt++; if ({instr[1], opcode[1], rdest[1], imm_upper[1], imm_lower[1]} !== 32'h0) $display("FAIL areset_fields: got %h expected 0", {instr[1], opcode[1], rdest[1], imm_upper[1], imm_lower[1]}); else pass_cnt++;
        total_cnt++; if ({mem_addr[1], pc_out[1]} !== 32'h0) $display("FAIL areset_addr: got %h expected 0", {mem_addr[1], pc_out[1]}); else pass_cnt++;
        @(negedge clk);
        step();
        reset[1] = 1'b1;
        wait_strobe(1, 5, seen, cyc);
        total_cnt++; if ({seen, mem_addr[1]} !== {1'b1, 16'h0100}) $display("FAIL areset_first_strobe: got seen=%h addr=%h expected 1 0100", seen, mem_addr[1]); else pass_cnt++;
        wait_valid(1, 10, seen, cyc);
        total_cnt++; if ({pc_out[1], instr[1]} !== {16'h0100, memval(16'h0100)}) $display("FAIL areset_first_instr: got pc_out=%h instr=%h expected 0100 %h", pc_out[1], instr[1], memval(16'h0100)); else pass_cnt++;
        enable[1] = 1'b0;
        instr_ready[1] = 1'b1;
        repeat (3) step();
        instr_ready[1] = 1'b0;
    endtask

    // Transaction-level reference: every strobe must go to the next
    // sequential address (or the latest redirect target), must follow a cycle
    // with enable high, and must not overlap an outstanding or held fetch;
    // the instruction appears exactly MEM_LAT+1 cycles after its strobe
    // unless a redirect intervened, and stays put until accepted.
    task automatic test_random(input int d);
        logic [15:0] exp_next, pend_addr, held, raddr;
        bit pending, holding, prev_en, en, rdy, rd, exp_v;
        int s;
        int lat;
        lat = lat_of(d);
        idle_inputs(d);
        reset[d] = 1'b0;
        step();
        reset[d] = 1'b1;
        exp_next = pcr_of(d);
        pend_addr = 16'h0;
        held = 16'h0;
        pending = 1'b0;
        holding = 1'b0;
        prev_en = 1'b0;
        s = 0;
        for (int n = 0; n < 600; n++) begin
            exp_v = holding || (pending && n == s + lat + 1);
            total_cnt++; if (instr_valid[d] !== exp_v) $display("FAIL d%0d rnd_valid cycle %0d: got %h expected %h", d, n, instr_valid[d], exp_v); else pass_cnt++;
            if (pending && n == s + lat + 1) begin
                pending = 1'b0;
                holding = 1'b1;
                held = memval(pend_addr);
                total_cnt++; if (pc_out[d] !== pend_addr) $display("FAIL d%0d rnd_pc_out cycle %0d: got %h expected %h", d, n, pc_out[d], pend_addr); else pass_cnt++;
                total_cnt++; if ({opcode[d], rdest[d], imm_upper[d], imm_lower[d]} !== held) $display("FAIL d%0d rnd_fields cycle %0d: got %h expected %h", d, n, {opcode[d], rdest[d], imm_upper[d], imm_lower[d]}, held); else pass_cnt++;
            end
            if (holding) begin
                total_cnt++; if (instr[d] !== held) $display("FAIL d%0d rnd_instr cycle %0d: got %h expected %h", d, n, instr[d], held); else pass_cnt++;
            end
            if (mem_rd_en[d] === 1'b1) begin
                total_cnt++; if ({pending, holding, prev_en} !== 3'b001) $display("FAIL d%0d rnd_strobe_allowed cycle %0d: got pending=%0d holding=%0d enable=%0d expected 0 0 1", d, n, pending, holding, prev_en); else pass_cnt++;
                total_cnt++; if (mem_addr[d] !== exp_next) $display("FAIL d%0d rnd_strobe_addr cycle %0d: got %h expected %h", d, n, mem_addr[d], exp_next); else pass_cnt++;
                pending = 1'b1;
                s = n;
                pend_addr = exp_next;
                exp_next = exp_next + 16'h1;
            end
            en  = ($urandom_range(0, 7) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            rd  = ($urandom_range(0, 15) == 0);
            raddr = 16'($urandom);
            if ($urandom_range(0, 3) == 0) raddr = 16'hFFFE | 16'($urandom_range(0, 1));
            enable[d] = en;
            instr_ready[d] = rdy;
            redirect[d] = rd;
            redirect_addr[d] = raddr;
            if (rd) begin
                pending = 1'b0;
                holding = 1'b0;
                exp_next = raddr;
            end else if (holding && rdy) begin
                holding = 1'b0;
            end
            prev_en = en;
            step();
        end
        idle_inputs(d);
        step();
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            reset[d] = 1'b0;
            idle_inputs(d);
        end
        step();
        test_reset(0);
        test_reset(1);
        test_basic_fetch();
        test_stall();
        test_enable_gate();
        test_wrap();
        test_redirect_wait();
        test_async_reset();
        test_random(0);
        test_random(1);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
